// File: rtl/throw_sequencer.sv
// ---------------------------------------------------------------------------
// throw_sequencer
//
// Turn/throw controller in the clk40MHz domain. It sits between the player
// selection logic, the mouse path and the throw datapath:
//   * holds play until both players report ready,
//   * decides whose turn it is from turn[0] versus the local player id,
//   * on a local turn charges a power value while the left button is held
//     and fires a single throw pulse on release,
//   * on a remote turn waits for the remote throw edge,
//   * waits for the throw to finish (or time out), then advances the shared
//     turn counter.
//
// Parameters
//   CHARGE_DIV      clk cycles per power step (min 1)
//   FLIGHT_TIMEOUT  clk cycles spent in FLIGHT before a forced advance (min 1)
//
// Build option
//   THROW_PINGPONG_EN  when defined, power ramps 0..31..0..31 (triangle) while
//                      the button is held instead of saturating at 31.
//
// Ports
//   clk40MHz          in   system clock
//   rst               in   asynchronous, active-high reset
//   in_player1_ready  in   player 1 ready (level)
//   in_player2_ready  in   player 2 ready (level)
//   current_player    in   local player id: 0 = P1, 1 = P2
//   left              in   mouse left button from the 100 MHz domain
//   in_throw_flag     in   remote player's throw; rising edge is used
//   end_throw         in   throw datapath finished (1-cycle pulse)
//   throw_flag        out  local throw fire, exactly one cycle wide
//   power             out  charged power 0..31, held through FLIGHT
//   turn              out  turn counter, wraps 7 -> 0
//   my_turn           out  local player's turn while aiming/charging
//   seq_state         out  encoded FSM state (debug/LED)
// ---------------------------------------------------------------------------
module throw_sequencer #(
  parameter int unsigned CHARGE_DIV     = 1_000_000,
  parameter int unsigned FLIGHT_TIMEOUT = 200_000_000
) (
  input  logic       clk40MHz,
  input  logic       rst,
  input  logic       in_player1_ready,
  input  logic       in_player2_ready,
  input  logic       current_player,
  input  logic       left,
  input  logic       in_throw_flag,
  input  logic       end_throw,
  output logic       throw_flag,
  output logic [4:0] power,
  output logic [2:0] turn,
  output logic       my_turn,
  output logic [2:0] seq_state
);

  // Counter widths; a divider of 1 still needs a 1-bit register.
  localparam int PW = (CHARGE_DIV     > 1) ? $clog2(CHARGE_DIV)     : 1;
  localparam int TW = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CHARGE_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(FLIGHT_TIMEOUT - 1);

  localparam logic [4:0] POWER_MAX = 5'd31;

  typedef enum logic [2:0] {
    WAIT_READY = 3'd0,
    ARM        = 3'd1,
    AIM        = 3'd2,
    CHARGE     = 3'd3,
    FLIGHT     = 3'd4,
    ADVANCE    = 3'd5
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [TW-1:0] tmo;

`ifdef THROW_PINGPONG_EN
  logic          ramp_up;
`endif

  // -------------------------------------------------------------------------
  // Input conditioning: 2-FF synchroniser on the mouse button (it comes from
  // the 100 MHz domain) and one history register per edge-detected input.
  // -------------------------------------------------------------------------
  logic left_meta;
  logic left_s;
  logic left_d;
  logic thr_d;

  // NOTE: sequential state is always assigned with <=, so every register in
  // this block samples the pre-edge value of its source; blocking '=' here
  // would collapse the synchroniser chain into a single flop.
  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      left_meta <= 1'b0;
      left_s    <= 1'b0;
      left_d    <= 1'b0;
      thr_d     <= 1'b0;
    end else begin
      left_meta <= left;
      left_s    <= left_meta;
      left_d    <= left_s;
      thr_d     <= in_throw_flag;
    end
  end

  logic left_rise;
  logic left_fall;
  logic thr_rise;
  logic both_ready;
  logic local_turn;

  assign left_rise  =  left_s & ~left_d;
  assign left_fall  = ~left_s &  left_d;
  assign thr_rise   =  in_throw_flag & ~thr_d;
  assign both_ready =  in_player1_ready & in_player2_ready;
  assign local_turn = (turn[0] == current_player);

  // Decoded from registered state/turn, so it tracks the FSM without lag.
  assign my_turn   = ((state == AIM) || (state == CHARGE)) && local_turn;
  assign seq_state = state;

  // -------------------------------------------------------------------------
  // Turn/throw FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      state      <= WAIT_READY;
      power      <= '0;
      turn       <= '0;
      throw_flag <= 1'b0;
      presc      <= '0;
      tmo        <= '0;
`ifdef THROW_PINGPONG_EN
      ramp_up    <= 1'b1;
`endif
    end else begin
      // Fire pulse is one cycle wide unless re-asserted below.
      throw_flag <= 1'b0;

      if (!both_ready && (state != WAIT_READY)) begin
        // A player dropped out: abandon the turn but keep the turn count.
        state <= WAIT_READY;
        power <= '0;
      end else begin
        case (state)
          WAIT_READY: begin
            if (both_ready) begin
              state <= ARM;
            end
          end

          ARM: begin
            power <= '0;
            // A local player must let go of the button first, so a button
            // still held from the previous turn can never start a charge.
            if (!local_turn || !left_s) begin
              state <= AIM;
            end
          end

          AIM: begin
            if (local_turn) begin
              if (left_rise) begin
                state   <= CHARGE;
                presc   <= '0;
`ifdef THROW_PINGPONG_EN
                ramp_up <= 1'b1;
`endif
              end
            end else if (thr_rise) begin
              state <= FLIGHT;
              tmo   <= '0;
            end
          end

          CHARGE: begin
            if (left_fall) begin
              // Release takes priority over a coincident power step, so the
              // fired power is the value the player saw when letting go.
              if (power != 5'd0) begin
                throw_flag <= 1'b1;
                state      <= FLIGHT;
                tmo        <= '0;
              end else begin
                state <= AIM;
              end
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
`ifdef THROW_PINGPONG_EN
              if (ramp_up) begin
                if (power == POWER_MAX) begin
                  ramp_up <= 1'b0;
                  power   <= power - 5'd1;
                end else begin
                  power   <= power + 5'd1;
                end
              end else begin
                if (power == 5'd0) begin
                  ramp_up <= 1'b1;
                  power   <= power + 5'd1;
                end else begin
                  power   <= power - 5'd1;
                end
              end
`else
              if (power != POWER_MAX) begin
                power <= power + 5'd1;
              end
`endif
            end else begin
              presc <= presc + 1'b1;
            end
          end

          FLIGHT: begin
            // end_throw and timeout in the same cycle give one advance.
            if (end_throw || (tmo == TMO_LAST)) begin
              state <= ADVANCE;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end

          ADVANCE: begin
            turn  <= turn + 3'd1;
            power <= '0;
            state <= ARM;
          end

          default: begin
            state <= WAIT_READY;
            power <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_throw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_throw_sequencer
//
// Directed bench for throw_sequencer with CHARGE_DIV=4, FLIGHT_TIMEOUT=64.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, i.e. after the edge's updates have settled.
//
// Timing reference for a local throw (edge E0 = the edge before the button
// is driven high): the synchroniser makes left_s high after E2, the rise is
// acted on at E3 (AIM -> CHARGE), and power steps to k at E(3+4k). A release
// driven after En is acted on at E(n+3).
// ---------------------------------------------------------------------------
module tb_throw_sequencer;

  logic       clk40MHz;
  logic       rst;
  logic       in_player1_ready;
  logic       in_player2_ready;
  logic       current_player;
  logic       left;
  logic       in_throw_flag;
  logic       end_throw;
  logic       throw_flag;
  logic [4:0] power;
  logic [2:0] turn;
  logic       my_turn;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;

  // Throw pulse monitor: counts pulses and any pulse wider than one cycle.
  int   throw_cnt = 0;
  int   wide_cnt  = 0;
  logic throw_prev = 1'b0;

  throw_sequencer #(
    .CHARGE_DIV     (4),
    .FLIGHT_TIMEOUT (64)
  ) dut (
    .clk40MHz         (clk40MHz),
    .rst              (rst),
    .in_player1_ready (in_player1_ready),
    .in_player2_ready (in_player2_ready),
    .current_player   (current_player),
    .left             (left),
    .in_throw_flag    (in_throw_flag),
    .end_throw        (end_throw),
    .throw_flag       (throw_flag),
    .power            (power),
    .turn             (turn),
    .my_turn          (my_turn),
    .seq_state        (seq_state)
  );

  initial clk40MHz = 1'b0;
  always #5 clk40MHz = ~clk40MHz;

  always @(negedge clk40MHz) begin
    if (throw_flag === 1'b1) begin
      throw_cnt = throw_cnt + 1;
      if (throw_prev === 1'b1) wide_cnt = wide_cnt + 1;
    end
    throw_prev = throw_flag;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk40MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  initial begin
    rst              = 1'b1;
    in_player1_ready = 1'b0;
    in_player2_ready = 1'b0;
    current_player   = 1'b0;
    left             = 1'b0;
    in_throw_flag    = 1'b0;
    end_throw        = 1'b0;
    step(3);

    // ---- reset values ----
    check("rst_state",      32'(seq_state),  32'd0);
    check("rst_power",      32'(power),      32'd0);
    check("rst_turn",       32'(turn),       32'd0);
    check("rst_throw_flag", 32'(throw_flag), 32'd0);
    check("rst_my_turn",    32'(my_turn),    32'd0);

    // ---- ready gating: only P1 ready ----
    rst              = 1'b0;
    in_player1_ready = 1'b1;
    step(100);
    check("p1_only_state", 32'(seq_state), 32'd0);
    check("p1_only_throw", 32'(throw_cnt), 32'd0);

    in_player2_ready = 1'b1;
    step(1);
    check("ready_arm",     32'(seq_state), 32'd1);
    step(1);
    check("ready_aim",     32'(seq_state), 32'd2);
    check("ready_my_turn", 32'(my_turn),   32'd1);

    // ---- local throw: hold 40 cycles ----
    left = 1'b1;
    step(40);
    check("hold40_charge", 32'(seq_state), 32'd3);
    check("hold40_nofire", 32'(throw_cnt), 32'd0);
    left = 1'b0;
    step(3);                               // release acted on at E43
    check("rel40_state",   32'(seq_state),  32'd4);
    check("rel40_fire",    32'(throw_flag), 32'd1);
    check("rel40_power",   32'(power),      32'd9);
    step(1);
    check("rel40_fire_end", 32'(throw_flag), 32'd0);
    check("rel40_hold_pwr", 32'(power),      32'd9);
    step(4);
    end_throw = 1'b1;
    step(1);
    end_throw = 1'b0;
    check("end1_advance",  32'(seq_state), 32'd5);
    step(1);
    check("end1_turn",     32'(turn),      32'd1);
    check("end1_power",    32'(power),     32'd0);
    step(2);
    check("end1_remote_aim", 32'(seq_state), 32'd2);
    check("end1_my_turn",    32'(my_turn),   32'd0);

    // ---- long hold (P2 local on turn 1) ----
    current_player = 1'b1;
    step(2);
    check("p2_my_turn", 32'(my_turn), 32'd1);
    left = 1'b1;
`ifdef THROW_PINGPONG_EN
    step(130);                             // peak reached at E127
    check("pp_peak",   32'(power), 32'd31);
    step(20);                              // falling: 26 from E147
    check("pp_fall",   32'(power), 32'd26);
    step(20);                              // 20 from E171; release at E173
    left = 1'b0;
    step(3);
    check("pp_fire",   32'(throw_flag), 32'd1);
    check("pp_power",  32'(power),      32'd20);
`else
    step(200);
    check("sat_power", 32'(power),      32'd31);
    check("sat_state", 32'(seq_state),  32'd3);
    check("sat_nofire", 32'(throw_cnt), 32'd1);
    left = 1'b0;
    step(3);
    check("sat_fire",  32'(throw_flag), 32'd1);
    check("sat_rel_power", 32'(power),  32'd31);
`endif
    check("long_flight", 32'(seq_state), 32'd4);
    step(2);
    end_throw = 1'b1;
    step(1);
    end_throw = 1'b0;
    step(1);
    check("end2_turn", 32'(turn), 32'd2);

    // ---- zero-power release: press/release within 3 cycles ----
    current_player = 1'b0;
    step(2);
    check("zero_aim",     32'(seq_state), 32'd2);
    check("zero_my_turn", 32'(my_turn),   32'd1);
    left = 1'b1;
    step(2);
    left = 1'b0;
    step(1);
    check("zero_charge",  32'(seq_state), 32'd3);
    step(2);
    check("zero_back_aim", 32'(seq_state), 32'd2);
    check("zero_power",    32'(power),     32'd0);
    step(4);
    check("zero_nofire",   32'(throw_cnt), 32'd2);

    // ---- remote turn, timeout without end_throw ----
    current_player = 1'b1;
    step(2);
    in_throw_flag = 1'b1;
    step(1);
    in_throw_flag = 1'b0;
    check("remote_flight", 32'(seq_state), 32'd4);
    step(63);
    check("tmo_not_yet",   32'(seq_state), 32'd4);
    check("tmo_turn_held", 32'(turn),      32'd2);
    step(1);
    check("tmo_advance",   32'(seq_state), 32'd5);
    step(1);
    check("tmo_turn",      32'(turn),      32'd3);

    // ---- end_throw coinciding with timeout ----
    current_player = 1'b0;
    step(2);
    in_throw_flag = 1'b1;
    step(1);
    in_throw_flag = 1'b0;
    check("coin_flight", 32'(seq_state), 32'd4);
    step(63);
    end_throw = 1'b1;
    step(1);
    end_throw = 1'b0;
    check("coin_advance", 32'(seq_state), 32'd5);
    step(1);
    step(5);
    check("coin_turn",    32'(turn),      32'd4);
    check("coin_aim",     32'(seq_state), 32'd2);

    // ---- remote edge ignored on a local turn ----
    in_throw_flag = 1'b1;
    step(1);
    in_throw_flag = 1'b0;
    step(3);
    check("ignore_remote", 32'(seq_state), 32'd2);

    // ---- abort: drop P2 ready mid-CHARGE ----
    left = 1'b1;
    step(10);
    check("abort_charge", 32'(seq_state), 32'd3);
    check("abort_power1", 32'(power),     32'd1);
    in_player2_ready = 1'b0;
    step(1);
    check("abort_state",  32'(seq_state), 32'd0);
    check("abort_power",  32'(power),     32'd0);
    check("abort_turn",   32'(turn),      32'd4);
    left = 1'b0;
    step(3);
    check("abort_nofire", 32'(throw_cnt), 32'd2);
    in_player2_ready = 1'b1;
    step(4);
    check("rejoin_aim",   32'(seq_state), 32'd2);

    // ---- async reset mid-FLIGHT ----
    current_player = 1'b1;
    step(2);
    in_throw_flag = 1'b1;
    step(1);
    in_throw_flag = 1'b0;
    check("rst_pre_flight", 32'(seq_state), 32'd4);
    step(5);
    #2;
    rst = 1'b1;
    #1;                                    // no clock edge in between
    check("arst_turn",  32'(turn),       32'd0);
    check("arst_throw", 32'(throw_flag), 32'd0);
    check("arst_state", 32'(seq_state),  32'd0);
    check("arst_power", 32'(power),      32'd0);
    step(2);
    rst = 1'b0;
    step(2);

    check("throw_pulses", 32'(throw_cnt), 32'd2);
    check("throw_width",  32'(wide_cnt),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
